// File: rtl/parity_rx_if.sv
// Serial receiver bundle: line input plus completed-frame results.
// rx in; data, valid, parity_err, frame_err, busy out of the receiver.
interface parity_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   modport master (
      output rx,
      input  data, valid, parity_err, frame_err, busy
   );

   modport slave (
      input  rx,
      output data, valid, parity_err, frame_err, busy
   );
endinterface

// File: rtl/parity_rx.sv
// Serial receiver: start, 8 data LSB first, parity, stop.
// Ports: clk, rst_n (async low), bus (rx in; data/valid/errors/busy out).
module parity_rx #(
   parameter int CLKS_PER_BIT = 8,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   parity_rx_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic          par_q, par_d;
   logic          rx_m, rx_s;
   logic          done;
   logic          pe_n;
   logic [7:0]    data_q;
   logic          valid_q, pe_q, fe_q;

   // Line synchronizer; resets to idle-high so reset never
   // looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= bus.rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
      end
   end

   // Parity mismatch of the frame just completed.
   assign pe_n = par_q ^ (^sh_q) ^ PARITY_ODD;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + ONE;
      idx_d   = idx_q;
      sh_d    = sh_q;
      par_d   = par_q;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // Mid start bit: a high line here is a glitch.
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               sh_d  = {rx_s, sh_q[7:1]};
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Results are captured on the stop sample and held
   // until the next completed frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         valid_q <= done;
         if (done) begin
            data_q <= sh_q;
            pe_q   <= pe_n;
            fe_q   <= ~rx_s;
         end
      end
   end

   assign bus.data       = data_q;
   assign bus.valid      = valid_q;
   assign bus.parity_err = pe_q;
   assign bus.frame_err  = fe_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_parity_rx.sv
// Bench for parity_rx: even and odd instances share one line;
// a scoreboard per instance checks every completed frame.
module tb_parity_rx;
   localparam int CPB = 8;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic clk;
   logic rst_n;
   logic rx;
   int   nvec;
   int   nmis;
   logic [7:0] last;
   exp_t qe[$];
   exp_t qo[$];

   parity_rx_if be ();
   parity_rx_if bo ();

   assign be.rx = rx;
   assign bo.rx = rx;

   parity_rx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_ODD  (1'b0)
   ) u_even (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (be.slave)
   );

   parity_rx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_ODD  (1'b1)
   ) u_odd (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bo.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference: count ones, compare with the received bits.
   function automatic exp_t model(input logic [7:0] d,
                                  input logic p,
                                  input logic s,
                                  input logic odd);
      exp_t e;
      int   ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      e.d  = d;
      e.pe = (p != logic'((ones % 2) != 0) ^ odd);
      e.fe = (s == 1'b0);
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && be.valid) begin
         if (qe.size() == 0) begin
            chk("even_unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = qe.pop_front();
            chk("even_data", be.data, e.d);
            chk("even_parity_err", be.parity_err, e.pe);
            chk("even_frame_err", be.frame_err, e.fe);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bo.valid) begin
         if (qo.size() == 0) begin
            chk("odd_unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = qo.pop_front();
            chk("odd_data", bo.data, e.d);
            chk("odd_parity_err", bo.parity_err, e.pe);
            chk("odd_frame_err", bo.frame_err, e.fe);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] d,
                       input logic p,
                       input logic s,
                       input int maxc);
      logic [10:0] bits;
      int c;
      bits = {s, p, d, 1'b0};
      c = 0;
      for (int b = 0; b < 11; b++) begin
         for (int k = 0; k < CPB; k++) begin
            if (c >= maxc) return;
            rx = bits[b];
            tick();
            c++;
         end
      end
   endtask

   task automatic frame(input logic [7:0] d,
                        input logic p,
                        input logic s);
      qe.push_back(model(d, p, s, 1'b0));
      qo.push_back(model(d, p, s, 1'b1));
      last = d;
      send(d, p, s, 1 << 20);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_even_data"}, be.data, 8'h00);
      chk({tag, "_even_valid"}, be.valid, 0);
      chk({tag, "_even_pe"}, be.parity_err, 0);
      chk({tag, "_even_fe"}, be.frame_err, 0);
      chk({tag, "_even_busy"}, be.busy, 0);
      chk({tag, "_odd_data"}, bo.data, 8'h00);
      chk({tag, "_odd_valid"}, bo.valid, 0);
      chk({tag, "_odd_pe"}, bo.parity_err, 0);
      chk({tag, "_odd_fe"}, bo.frame_err, 0);
      chk({tag, "_odd_busy"}, bo.busy, 0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_even_busy"}, be.busy, 0);
      chk({tag, "_odd_busy"}, bo.busy, 0);
   endtask

   initial begin
      logic [7:0] d;
      logic       p;
      logic       s;
      logic       seen;
      nvec  = 0;
      nmis  = 0;
      last  = 8'h00;
      rx    = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("reset");
      tick();
      rst_n = 1'b1;
      idle(4);

      frame(8'hA5, 1'b0, 1'b1);
      idle(2 * CPB);
      chk_idle("a5_after");

      frame(8'h01, 1'b0, 1'b1);
      frame(8'h03, 1'b0, 1'b1);
      idle(2 * CPB);

      frame(8'hFF, 1'b0, 1'b0);
      idle(3 * CPB);
      chk_idle("ff_after");

      // Glitch on the line: busy must pulse, nothing else.
      seen = 1'b0;
      rx = 1'b0;
      tick();
      tick();
      rx = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (be.busy && bo.busy) seen = 1'b1;
      end
      chk("false_start_busy_seen", seen, 1);
      idle(4);
      chk_idle("false_start_after");
      chk("false_start_even_data", be.data, last);
      chk("false_start_odd_data", bo.data, last);

      // Reset in the middle of the data bits.
      send(8'h3C, 1'b0, 1'b1, 4 * CPB);
      rx = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_reset("midframe_reset");
      last = 8'h00;
      idle(3);
      rst_n = 1'b1;
      idle(4);
      frame(8'h3C, 1'b0, 1'b1);
      idle(2 * CPB);

      frame(8'h55, 1'b0, 1'b1);
      frame(8'hAA, 1'b0, 1'b1);
      frame(8'h00, 1'b1, 1'b1);
      idle(2 * CPB);

      for (int n = 0; n < 24; n++) begin
         d = 8'($urandom);
         if ($urandom_range(0, 3) == 0) p = 1'($urandom);
         else p = ^d;
         s = ($urandom_range(0, 7) != 0);
         frame(d, p, s);
         if (!s) idle(3 * CPB);
         else idle($urandom_range(0, 3));
      end

      idle(3 * CPB);
      chk_idle("end");
      chk("even_pending_frames", qe.size(), 0);
      chk("odd_pending_frames", qo.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nmis);
      $finish;
   end
endmodule

// File: doc/parity_rx.md
PARITY_RX -- requirements
Module: parity_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 8, giving clock cycles per serial bit (even, >= 4).
REQ-002 The block SHALL have parameter PARITY_ODD, default 0: 0 = even parity expected, 1 = odd parity expected.
REQ-003 The block SHALL have port clk  input  1  single system clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 The block SHALL have port data  output  8  last received data byte.
REQ-007 The block SHALL have port valid  output  1  one-cycle pulse when a frame completes.
REQ-008 The block SHALL have port parity_err  output  1  parity mismatch flag for the completed frame.
REQ-009 The block SHALL have port frame_err  output  1  stop-bit-low flag for the completed frame.
REQ-010 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 Frame format SHALL be: start (0), 8 data bits LSB first, 1 parity bit, 1 stop (1).
REQ-012 rx SHALL pass through a 2-flop synchronizer; all timing below refers to the synchronized signal rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE: rx_s = 0 -> START, cycle counter cleared to 0.
REQ-015 START: at counter = CLKS_PER_BIT/2 - 1, sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (false start, no output change).
REQ-016 DATA: each sample SHALL occur when the counter reaches CLKS_PER_BIT - 1, then the counter clears; bit i goes to shift register position i; after the 8th sample -> PARITY.
REQ-017 PARITY: one sample at the same spacing; the expected bit SHALL be XOR of the 8 data bits XOR PARITY_ODD; -> STOP.
REQ-018 STOP: one sample at the same spacing, then -> IDLE in the same cycle, with the next start bit accepted from the following cycle.
REQ-019 On the cycle after the stop sample, valid SHALL be 1 for exactly one cycle; data, parity_err and frame_err SHALL be updated in that same cycle.
REQ-020 parity_err SHALL be 1 iff the sampled parity bit differs from the expected bit; frame_err SHALL be 1 iff the sampled stop bit is 0.
REQ-021 data SHALL be delivered even when either error flag is set.
REQ-022 data, parity_err and frame_err SHALL hold their values until the next valid pulse.
REQ-023 A false start or a reset SHALL never produce valid.
REQ-024 If rx_s is low in IDLE right after a frame with frame_err, the block SHALL treat it as a new start bit; there is no break detection.

Reset
REQ-025 Reset (rst_n = 0) SHALL immediately force: FSM to IDLE, counters to 0, synchronizer flops to 1, data = 8'h00, valid = 0, parity_err = 0, frame_err = 0, busy = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame without a valid pulse; after release the block SHALL wait for a fresh falling edge.
REQ-027 Reset release SHALL be tolerated on any cycle; the first start bit SHALL be detected no earlier than 2 cycles after release, because of the synchronizer.

Verification (CLKS_PER_BIT = 8 unless stated)
REQ-028 Frame 0xA5, parity bit 0, stop 1, PARITY_ODD = 0 -> one valid pulse, data = 8'hA5, parity_err = 0, frame_err = 0, busy = 0 afterwards.
REQ-029 Frame 0x01, parity bit 0 -> valid with data = 8'h01 and parity_err = 1; next frame 0x03, parity bit 0 -> parity_err returns to 0.
REQ-030 Frame 0xFF, parity bit 0, stop bit 0 -> valid, data = 8'hFF, frame_err = 1, parity_err = 0.
REQ-031 rx low for 2 cycles then high -> busy pulses, then IDLE; no valid; data keeps its previous value.
REQ-032 rst_n pulsed low during DATA of frame 0x3C -> no valid, all outputs at reset values; next frame 0x3C with parity 0 -> valid, data = 8'h3C.
REQ-033 Back-to-back frames 0x55 then 0xAA with no idle gap, and PARITY_ODD = 1 with frame 0x00 and parity bit 1 -> exactly one valid per frame, correct data each time, no error flags.
